// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment typedef, blank pattern and the
// active-high hex decode table (bit0 = a ... bit6 = g).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_OFF = 7'h00;

  // Entry 0 sits in the least significant slice, so SEG7_HEX_LUT[n] decodes n.
  localparam logic [15:0][6:0] SEG7_HEX_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high seven-segment decoder, shared by any
// display consumer that needs a hex glyph.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = SEG7_HEX_LUT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadowed digits and blanking.
// Optional macro LEADING_ZERO_BLANK_EN also blanks leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam seg7_t POL_SEG = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] POL_AN = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    chg_q, chg_d;
  seg7_t                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [NUM_DIGITS-1:0]   an_hi;
  seg7_t                   glyph;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_q, lz_d;

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_d     = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (value[4*i +: 4] == 4'h0);
      lz_d[i]  = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_q <= '0;
    end else if (load) begin
      lz_q <= lz_d;
    end
  end

  assign eff_blank = blank_q | lz_q;
`else
  assign eff_blank = blank_q;
`endif

  assign tick = (presc_q == PRE_LAST);

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    an_hi     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_hi[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = val_q[4*i +: 4];
        cur_blank = eff_blank[i];
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble_i (cur_nib),
    .seg_o    (glyph)
  );

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    chg_d = tick && (NUM_DIGITS > 1);
    seg_d = (cur_blank ? SEG7_OFF : glyph) ^ POL_SEG;
    // Anode stays dark for the first output cycle of a new digit (anti-ghosting).
    an_d  = (chg_q ? '0 : an_hi) ^ POL_AN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= '0;
      blank_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      chg_q   <= 1'b0;
      seg_q   <= POL_SEG;
      an_q    <= POL_AN;
    end else begin
      if (load) begin
        val_q   <= value;
        blank_q <= blank;
      end
      presc_q <= presc_d;
      idx_q   <= idx_d;
      chg_q   <= chg_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle refresh, active-low.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
  } scan_vec_t;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .blank     (blank),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input logic [1:0] k, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (digit_idx !== k && steps < 40);
    if (digit_idx !== k) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idx: digit_idx=%0d, expected %0d within 40 cycles", digit_idx, k);
    end
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] b);
    value = v;
    blank = b;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic run_scan(input string tag, input scan_vec_t v[4]);
    int s;
    for (int i = 0; i < 4; i++) begin
      wait_idx(v[i].idx, s);
      if (i > 0) chk($sformatf("%s period d%0d", tag, i), s + 2, 4);
      step();
      chk($sformatf("%s ghost an d%0d", tag, v[i].idx), {28'h0, an}, {28'h0, 4'hF});
      chk($sformatf("%s early seg d%0d", tag, v[i].idx), {25'h0, seg}, {25'h0, v[i].seg});
      step();
      chk($sformatf("%s an d%0d", tag, v[i].idx), {28'h0, an}, {28'h0, v[i].an});
      chk($sformatf("%s seg d%0d", tag, v[i].idx), {25'h0, seg}, {25'h0, v[i].seg});
    end
  endtask

  initial begin
    scan_vec_t scan_1234 [4];
    scan_vec_t scan_lz50 [4];
    scan_vec_t scan_lz00 [4];
    int s;

    scan_1234 = '{'{2'd2, 4'hB, 7'h24}, '{2'd3, 4'h7, 7'h79},
                  '{2'd0, 4'hE, 7'h19}, '{2'd1, 4'hD, 7'h30}};
    scan_lz50 = '{'{2'd2, 4'hB, 7'h7F}, '{2'd3, 4'h7, 7'h7F},
                  '{2'd0, 4'hE, 7'h40}, '{2'd1, 4'hD, 7'h12}};
    scan_lz00 = '{'{2'd2, 4'hB, 7'h7F}, '{2'd3, 4'h7, 7'h7F},
                  '{2'd0, 4'hE, 7'h40}, '{2'd1, 4'hD, 7'h7F}};

    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    blank = '0;
    repeat (3) step();
    chk("reset seg", {25'h0, seg}, {25'h0, 7'h7F});
    chk("reset an", {28'h0, an}, {28'h0, 4'hF});
    chk("reset idx", {30'h0, digit_idx}, 32'h0);

    rst = 1'b0;
    load_val(16'h1234, 4'h0);
    wait_idx(2'd1, s);
    chk("first tick latency", s + 1, 4);
    run_scan("scan1234", scan_1234);

    for (int n = 0; n < 16; n++) begin
      wait_idx(2'd1, s);
      load_val(16'(n), 4'h0);
      wait_idx(2'd0, s);
      step();
      chk($sformatf("decode %0h ghost an", n), {28'h0, an}, {28'h0, 4'hF});
      chk($sformatf("decode %0h early seg", n), {25'h0, seg}, {25'h0, ~lut[n]});
      step();
      chk($sformatf("decode %0h an", n), {28'h0, an}, {28'h0, 4'hE});
      chk($sformatf("decode %0h seg", n), {25'h0, seg}, {25'h0, ~lut[n]});
    end

    load_val(16'h1234, 4'b0100);
    wait_idx(2'd2, s);
    step();
    chk("blank d2 ghost an", {28'h0, an}, {28'h0, 4'hF});
    chk("blank d2 seg early", {25'h0, seg}, {25'h0, 7'h7F});
    step();
    chk("blank d2 an", {28'h0, an}, {28'h0, 4'hB});
    chk("blank d2 seg", {25'h0, seg}, {25'h0, 7'h7F});
    wait_idx(2'd3, s);
    step();
    step();
    chk("blank d3 an", {28'h0, an}, {28'h0, 4'h7});
    chk("blank d3 seg", {25'h0, seg}, {25'h0, 7'h79});

    wait_idx(2'd0, s);
    step();
    step();
    step();
    value = 16'hA5C0;
    blank = 4'h0;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("tickload idx", {30'h0, digit_idx}, 32'h1);
    step();
    chk("tickload ghost an", {28'h0, an}, {28'h0, 4'hF});
    chk("tickload early seg", {25'h0, seg}, {25'h0, 7'h46});
    step();
    chk("tickload an", {28'h0, an}, {28'h0, 4'hD});
    chk("tickload seg", {25'h0, seg}, {25'h0, 7'h46});

    load_val(16'h1234, 4'h0);
    wait_idx(2'd2, s);
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    blank = 4'hF;
    step();
    rst  = 1'b0;
    load = 1'b0;
    chk("midrst idx", {30'h0, digit_idx}, 32'h0);
    chk("midrst seg", {25'h0, seg}, {25'h0, 7'h7F});
    chk("midrst an", {28'h0, an}, {28'h0, 4'hF});
    step();
    chk("midrst shadow seg", {25'h0, seg}, {25'h0, 7'h40});
    chk("midrst shadow an", {28'h0, an}, {28'h0, 4'hE});
    wait_idx(2'd1, s);
    chk("midrst prescaler", s + 1, 4);

`ifdef LEADING_ZERO_BLANK_EN
    load_val(16'h0050, 4'h0);
    run_scan("lz0050", scan_lz50);
    load_val(16'h0000, 4'h0);
    run_scan("lz0000", scan_lz00);
`else
    load_val(16'h0050, 4'h0);
    scan_lz50[0].seg = 7'h40;
    scan_lz50[1].seg = 7'h40;
    run_scan("zero0050", scan_lz50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
